// File: rtl/logic_gates_bist.sv
// Built-in self-test wrapper for the two-input logic_gates block.
// Walks {a,b} through 00,01,10,11, waits a settle window, samples the seven
// gate outputs against golden values and keeps a verdict plus diagnostics.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | out of reset, waiting for start
// S_APPLY  | register {a,b} = vector index, load settle counter
// S_SETTLE | hold a/b while the settle counter runs down to zero
// S_SAMPLE | compare DUT outputs to golden, update diagnostics
// S_DONE   | verdict valid, diagnostics held until next start or reset
module logic_gates_bist #(
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_CNT_W     = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 a,
   output logic                 b,
   input  logic                 out_and,
   input  logic                 out_or,
   input  logic                 out_not,
   input  logic                 out_nand,
   input  logic                 out_nor,
   input  logic                 out_xor,
   input  logic                 out_xnor,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [1:0]           first_fail_vec,
   output logic [6:0]           fail_mask
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam bit                 HAS_SETTLE  = (SETTLE_CYCLES > 0);
   localparam logic [3:0]         SETTLE_LOAD = 4'(HAS_SETTLE ? SETTLE_CYCLES - 1 : 0);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_idx;
   logic [3:0]           r_settle;
   logic                 r_a;
   logic                 r_b;
   logic [ERR_CNT_W-1:0] r_err;
   logic [1:0]           r_ffv;
   logic [6:0]           r_mask;
   logic [6:0]           w_golden;
   logic [6:0]           w_dut;
   logic [6:0]           w_mis;

   // Golden responses from the registered stimulus, and the per-gate mismatch vector.
   always_comb begin
      w_golden = {~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b), ~(r_a & r_b), ~r_a, r_a | r_b, r_a & r_b};
      w_dut    = {out_xnor, out_xor, out_nor, out_nand, out_not, out_or, out_and};
      w_mis    = w_golden ^ w_dut;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode; start is only looked at in IDLE and DONE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_APPLY;
         S_APPLY:        w_next = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
         S_SETTLE:       if (r_settle == 4'd0) w_next = S_SAMPLE;
         S_SAMPLE:       w_next = (r_idx == 2'd3) ? S_DONE : S_APPLY;
         default:        w_next = S_IDLE;
      endcase
   end

   // Stimulus, settle timer and diagnostic registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx    <= 2'd0;
         r_settle <= 4'd0;
         r_a      <= 1'b0;
         r_b      <= 1'b0;
         r_err    <= '0;
         r_ffv    <= 2'd0;
         r_mask   <= 7'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_idx  <= 2'd0;
                  r_err  <= '0;
                  r_ffv  <= 2'd0;
                  r_mask <= 7'd0;
               end
            end
            S_APPLY: begin
               {r_a, r_b} <= r_idx;
               r_settle   <= SETTLE_LOAD;
            end
            S_SETTLE: begin
               if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
            end
            S_SAMPLE: begin
               if (|w_mis) begin
                  // err_count never returns to zero within a run, so zero means no failure yet.
                  if (r_err == '0)     r_ffv <= {r_a, r_b};
                  if (r_err != ERR_MAX) r_err <= r_err + ERR_CNT_W'(1);
               end
               r_mask <= r_mask | w_mis;
               r_idx  <= r_idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign a              = r_a;
   assign b              = r_b;
   assign busy           = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_SAMPLE);
   assign done           = (r_state == S_DONE);
   assign pass           = done && (r_err == '0);
   assign err_count      = r_err;
   assign first_fail_vec = r_ffv;
   assign fail_mask      = r_mask;

endmodule

// File: tb/tb_logic_gates_bist.sv
// Bench for logic_gates_bist: two instances (settle 1 / 3-bit count and
// settle 0 / 2-bit count) fed by a behavioural, fault-injectable gate model.
module tb_logic_gates_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         mode     = 0;
   logic [6:0] flip [4];

   logic       a1, b1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [1:0] ffv1;
   logic [6:0] mask1;
   logic [6:0] g1;

   logic       a2, b2, busy2, done2, pass2;
   logic [1:0] err2;
   logic [1:0] ffv2;
   logic [6:0] mask2;
   logic [6:0] g2;

   // Golden gate truth, bit order and,or,not,nand,nor,xor,xnor.
   function automatic logic [6:0] gold(input logic [1:0] v);
      logic x, y;
      x = v[1];
      y = v[0];
      return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
   endfunction

   // The gate block as seen by the BIST under the current fault mode.
   function automatic logic [6:0] gates(input logic [1:0] v);
      logic [6:0] g;
      g = gold(v);
      case (mode)
         1: g[5] = 1'b0;
         2: g[2] = v[1];
         3: g    = {g[6:2], g[0], g[1]};
         4: g    = g ^ flip[v];
         default: ;
      endcase
      return g;
   endfunction

   always_comb g1 = gates({a1, b1});
   always_comb g2 = gates({a2, b2});

   logic_gates_bist #(.SETTLE_CYCLES(1), .ERR_CNT_W(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1),
      .out_and(g1[0]), .out_or(g1[1]), .out_not(g1[2]), .out_nand(g1[3]),
      .out_nor(g1[4]), .out_xor(g1[5]), .out_xnor(g1[6]),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_vec(ffv1), .fail_mask(mask1)
   );

   logic_gates_bist #(.SETTLE_CYCLES(0), .ERR_CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2),
      .out_and(g2[0]), .out_or(g2[1]), .out_not(g2[2]), .out_nand(g2[3]),
      .out_nor(g2[4]), .out_xor(g2[5]), .out_xnor(g2[6]),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail_vec(ffv2), .fail_mask(mask2)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({a1, b1, busy1, done1, pass1} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl1: got %b want 00000", {a1, b1, busy1, done1, pass1});
      end
      n_checks++;
      if ({err1, ffv1, mask1} !== 12'h0) begin
         n_fail++;
         $display("FAIL reset_diag1: got %h want 000", {err1, ffv1, mask1});
      end
      n_checks++;
      if ({a2, b2, busy2, done2, pass2, err2, ffv2, mask2} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_all2: got %h want 0000", {a2, b2, busy2, done2, pass2, err2, ffv2, mask2});
      end
      rst_n = 1'b1;
   endtask

   // One full run under fault mode m, checked against the vector-level model.
   task automatic run(input string name, input int m, input bit pre);
      int         cnt;
      int         k1, k2;
      logic [6:0] mm, emask;
      logic [1:0] effv;
      int         e1, e2;
      mode  = m;
      cnt   = 0;
      emask = 7'd0;
      effv  = 2'd0;
      for (int v = 0; v < 4; v++) begin
         mm = gates(2'(v)) ^ gold(2'(v));
         if (mm != 7'd0) begin
            if (cnt == 0) effv = 2'(v);
            cnt++;
         end
         emask |= mm;
      end
      e1 = (cnt > 7) ? 7 : cnt;
      e2 = (cnt > 3) ? 3 : cnt;

      if (!pre) @(negedge clk);
      start = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({done1, err1, ffv1, mask1} !== 13'h0) begin
         n_fail++;
         $display("FAIL %s_clear_on_start: got %h want 0000", name, {done1, err1, ffv1, mask1});
      end

      k1 = 0;
      k2 = 0;
      for (int c = 0; c < 60; c++) begin
         if (busy1) begin
            if (k1 % 3 != 0) begin
               n_checks++;
               if ({a1, b1} !== 2'(k1 / 3)) begin
                  n_fail++;
                  $display("FAIL %s_ab1_k%0d: got %b want %b", name, k1, {a1, b1}, 2'(k1 / 3));
               end
            end
            k1++;
         end
         if (busy2) begin
            if (k2 % 2 == 1) begin
               n_checks++;
               if ({a2, b2} !== 2'(k2 / 2)) begin
                  n_fail++;
                  $display("FAIL %s_ab2_k%0d: got %b want %b", name, k2, {a2, b2}, 2'(k2 / 2));
               end
            end
            k2++;
         end
         if (!busy1 && !busy2) break;
         @(negedge clk);
      end

      n_checks++;
      if (k1 != 12) begin
         n_fail++;
         $display("FAIL %s_busy1_len: got %0d want 12", name, k1);
      end
      n_checks++;
      if (k2 != 8) begin
         n_fail++;
         $display("FAIL %s_busy2_len: got %0d want 8", name, k2);
      end
      n_checks++;
      if ({done1, pass1} !== {1'b1, cnt == 0}) begin
         n_fail++;
         $display("FAIL %s_verdict1: got done/pass %b want %b", name, {done1, pass1}, {1'b1, cnt == 0});
      end
      n_checks++;
      if ({err1, ffv1, mask1} !== {3'(e1), effv, emask}) begin
         n_fail++;
         $display("FAIL %s_diag1: got err=%0d ffv=%b mask=%h want err=%0d ffv=%b mask=%h",
                  name, err1, ffv1, mask1, e1, effv, emask);
      end
      n_checks++;
      if ({done2, pass2} !== {1'b1, cnt == 0}) begin
         n_fail++;
         $display("FAIL %s_verdict2: got done/pass %b want %b", name, {done2, pass2}, {1'b1, cnt == 0});
      end
      n_checks++;
      if ({err2, ffv2, mask2} !== {2'(e2), effv, emask}) begin
         n_fail++;
         $display("FAIL %s_diag2: got err=%0d ffv=%b mask=%h want err=%0d ffv=%b mask=%h",
                  name, err2, ffv2, mask2, e2, effv, emask);
      end
   endtask

   task automatic test_good();        run("good", 0, 1'b0); endtask
   task automatic test_xor_stuck();   run("xor_stuck", 1, 1'b0); endtask
   task automatic test_not_inverted(); run("not_inv", 2, 1'b0); endtask
   task automatic test_and_or_swap(); run("and_or_swap", 3, 1'b0); endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int v = 0; v < 4; v++)
            flip[v] = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(1, 127)) : 7'd0;
         run($sformatf("rand%0d", it), 4, 1'b0);
      end
   endtask

   task automatic test_reset_mid_run();
      int k;
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      k = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (busy1) k++;
         if (k == 8) break;
      end
      n_checks++;
      if ({a1, b1} !== 2'b10 || k != 8) begin
         n_fail++;
         $display("FAIL midrun_ab: got ab=%b k=%0d want ab=10 k=8", {a1, b1}, k);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({a1, b1, busy1, done1, pass1, err1, ffv1, mask1} !== 17'h0) begin
         n_fail++;
         $display("FAIL midrun_reset1: got %h want 00000", {a1, b1, busy1, done1, pass1, err1, ffv1, mask1});
      end
      n_checks++;
      if ({busy2, done2, err2} !== 4'h0) begin
         n_fail++;
         $display("FAIL midrun_reset2: got %h want 0", {busy2, done2, err2});
      end
      run("after_reset", 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run("b2b_faulty", 1, 1'b0);
      run("b2b_fixed", 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_good();
      test_xor_stuck();
      test_not_inverted();
      test_and_or_swap();
      test_random();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
